// File: rtl/psram_pkg.sv
// Shared types for the PSRAM arbiter: FSM states, read_write encodings, address type.
// Pure declarations; no logic or timing.
package psram_pkg;

  typedef logic [22:0] addr_t;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_START,
    ST_ACK,
    ST_BUSY,
    ST_GAP
  } state_t;

  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  // Cycles the arbiter stays in INIT after reset so a driver transaction can drain.
  localparam int INIT_CYCLES = 32;

endpackage

// File: rtl/psram_arbiter_if.sv
// Command/response bus between the arbiter (master) and the psram QPI driver (slave).
// Combinational bundle only; no latency or flow control of its own.
interface psram_arbiter_if;
  import psram_pkg::*;

  addr_t       address;
  logic [1:0]  read_write;
  logic        quad_start;
  logic [15:0] data_in;
  logic        endcommand;
  logic [15:0] data_out;

  modport master (
    output address, read_write, quad_start, data_in,
    input  endcommand, data_out
  );

  modport slave (
    input  address, read_write, quad_start, data_in,
    output endcommand, data_out
  );

endinterface

// File: rtl/psram_arb_holder.sv
// Single-entry valid/data holding register; captures din on req while empty.
// Latency 1 cycle; ready is low while full, release wins over a same-cycle request.
module psram_arb_holder #(
  parameter int W = 16
) (
  input  logic         mem_clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [W-1:0] din,
  input  logic         rel,
  output logic         ready,
  output logic         vld,
  output logic [W-1:0] dat
);

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (rel) begin
      vld <= 1'b0;
    end else if (req && !vld) begin
      vld <= 1'b1;
      dat <= din;
    end
  end

  assign ready = !vld;

endmodule

// File: rtl/psram_arbiter.sv
// Arbitrates a circular acquisition write stream and a random read port onto the psram QPI driver.
// One op per START/ACK/BUSY/GAP pass; writes win until RD_STARVE_LIMIT; PSRAM_ARB_TIMEOUT_EN adds a watchdog.
module psram_arbiter
  import psram_pkg::*;
#(
  parameter addr_t WR_BASE_ADDR    = 23'h000000,
  parameter int    DEPTH_WORDS     = 4096,
  parameter int    GAP_CYCLES      = 2,
  parameter int    RD_STARVE_LIMIT = 4,
  parameter int    TIMEOUT_CYCLES  = 64
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        qpi_on,
  input  logic        wr_req,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        wr_overflow,
  output addr_t       wr_ptr,
  output logic        wrapped,
  input  logic        rd_req,
  input  addr_t       rd_addr,
  output logic        rd_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
`ifdef PSRAM_ARB_TIMEOUT_EN
  output logic        err_timeout,
`endif
  psram_arbiter_if.master psram
);

  localparam int    GW     = $clog2(GAP_CYCLES + 1);
  localparam int    SW     = $clog2(RD_STARVE_LIMIT + 1);
  localparam addr_t WR_END = WR_BASE_ADDR + addr_t'(2 * DEPTH_WORDS);

  state_t         state, state_nxt;
  logic           qpi_q;
  logic [5:0]     init_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [SW-1:0]  starve_cnt;
  logic           op_is_rd;
  logic           wr_vld, rd_vld;
  logic [15:0]    wr_hold;
  addr_t          rd_hold;
  logic           grant_wr, launch, first_gap, gap_done;
  logic           wr_rel, rd_rel;
  addr_t          wr_ptr_inc;

  assign grant_wr  = wr_vld && (!rd_vld || starve_cnt < SW'(RD_STARVE_LIMIT));
  assign launch    = (state == ST_IDLE) && qpi_on && (wr_vld || rd_vld);
  assign first_gap = (state == ST_GAP) && (gap_cnt == '0);
  assign gap_done  = (state == ST_GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit, op_fail;

  assign to_hit = (state == ST_ACK || state == ST_BUSY) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // A timed-out op skips completion so the holder keeps its entry for a retry.
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      op_fail     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      to_cnt <= (state == ST_ACK || state == ST_BUSY) ? to_cnt + 1'b1 : '0;
      if (to_hit) begin
        op_fail     <= 1'b1;
        err_timeout <= 1'b1;
      end else if (launch) begin
        op_fail <= 1'b0;
      end
    end
  end
`else
  logic op_fail;
  assign op_fail = 1'b0;
`endif

  assign wr_rel     = first_gap && !op_is_rd && !op_fail;
  assign rd_rel     = first_gap &&  op_is_rd && !op_fail;
  assign wr_ptr_inc = wr_ptr + 23'd2;

  psram_arb_holder #(.W(16)) u_wr_hold (
    .mem_clk (mem_clk), .rst_n (rst_n), .req (wr_req), .din (wr_data),
    .rel (wr_rel), .ready (wr_ready), .vld (wr_vld), .dat (wr_hold)
  );

  psram_arb_holder #(.W(23)) u_rd_hold (
    .mem_clk (mem_clk), .rst_n (rst_n), .req (rd_req), .din (rd_addr),
    .rel (rd_rel), .ready (rd_ready), .vld (rd_vld), .dat (rd_hold)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_cnt == 6'(INIT_CYCLES) && qpi_on && qpi_q) state_nxt = ST_IDLE;
      ST_IDLE:  if (!qpi_on) state_nxt = ST_INIT;
                else if (launch) state_nxt = ST_START;
      ST_START: state_nxt = ST_ACK;
      ST_ACK:   if (!psram.endcommand) state_nxt = ST_BUSY;
      ST_BUSY:  if (psram.endcommand) state_nxt = ST_GAP;
      ST_GAP:   if (gap_done) state_nxt = qpi_on ? ST_IDLE : ST_INIT;
      default:  state_nxt = ST_INIT;
    endcase
`ifdef PSRAM_ARB_TIMEOUT_EN
    if (to_hit) state_nxt = ST_GAP;
`endif
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_INIT;
      qpi_q            <= 1'b0;
      init_cnt         <= '0;
      gap_cnt          <= '0;
      starve_cnt       <= '0;
      op_is_rd         <= 1'b0;
      psram.address    <= '0;
      psram.read_write <= RW_NONE;
      psram.data_in    <= '0;
    end else begin
      state   <= state_nxt;
      qpi_q   <= qpi_on;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      if (init_cnt != 6'(INIT_CYCLES)) init_cnt <= init_cnt + 1'b1;

      if (!rd_vld || (launch && !grant_wr)) starve_cnt <= '0;
      else if (launch) starve_cnt <= starve_cnt + 1'b1;

      // Bus fields are registered at grant and held through the whole op.
      if (launch) begin
        op_is_rd         <= !grant_wr;
        psram.address    <= grant_wr ? wr_ptr : rd_hold;
        psram.read_write <= grant_wr ? RW_WRITE : RW_READ;
        if (grant_wr) psram.data_in <= wr_hold;
      end else if (gap_done) begin
        psram.read_write <= RW_NONE;
      end
    end
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= WR_BASE_ADDR;
      wrapped     <= 1'b0;
      wr_overflow <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
    end else begin
      rd_valid <= rd_rel;
      if (rd_rel) rd_data <= psram.data_out;
      if (wr_req && !wr_ready) wr_overflow <= 1'b1;
      if (wr_rel) begin
        if (wr_ptr_inc == WR_END) begin
          wr_ptr  <= WR_BASE_ADDR;
          wrapped <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr_inc;
        end
      end
    end
  end

  assign psram.quad_start = (state == ST_START);
  assign busy             = (state != ST_INIT) && (state != ST_IDLE);

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a behavioural QPI driver model on the slave side.
// Optional timeout scenario runs when PSRAM_ARB_TIMEOUT_EN is defined.
module tb_psram_arbiter;
  import psram_pkg::*;

  logic        mem_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        qpi_on  = 1'b0;
  logic        wr_req  = 1'b0;
  logic [15:0] wr_data = '0;
  logic        rd_req  = 1'b0;
  addr_t       rd_addr = '0;
  logic        wr_ready, wr_overflow, wrapped, rd_ready, rd_valid, busy;
  addr_t       wr_ptr;
  logic [15:0] rd_data;
`ifdef PSRAM_ARB_TIMEOUT_EN
  logic        err_timeout;
`endif

  psram_arbiter_if bus();

  logic        m_endcmd = 1'b1;
  logic [15:0] m_dout   = '0;
  assign bus.endcommand = m_endcmd;
  assign bus.data_out   = m_dout;

  psram_arbiter dut (
    .mem_clk (mem_clk), .rst_n (rst_n), .qpi_on (qpi_on),
    .wr_req (wr_req), .wr_data (wr_data), .wr_ready (wr_ready),
    .wr_overflow (wr_overflow), .wr_ptr (wr_ptr), .wrapped (wrapped),
    .rd_req (rd_req), .rd_addr (rd_addr), .rd_ready (rd_ready),
    .rd_data (rd_data), .rd_valid (rd_valid), .busy (busy),
`ifdef PSRAM_ARB_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .psram (bus)
  );

  always #6 mem_clk = ~mem_clk;

  int errors = 0;
  int checks = 0;

  // Driver model: endcommand drops right after quad_start and returns three cycles later.
  int          qs_run = 0, qs_wide_cnt = 0, stab_cnt = 0, mcnt = 0;
  int          rv_run = 0, rv_cnt = 0, rv_wide_cnt = 0;
  bit          hang = 1'b0;
  addr_t       cap_addr;
  logic [1:0]  cap_rw;
  logic [15:0] cap_dat;
  logic [1:0]  log_rw[$];
  addr_t       log_addr[$];
  logic [15:0] log_dat[$];
  logic [15:0] mem[addr_t];

  always @(negedge mem_clk) begin
    if (bus.quad_start === 1'b1) begin
      qs_run++;
      if (qs_run > 1) qs_wide_cnt++;
      log_rw.push_back(bus.read_write);
      log_addr.push_back(bus.address);
      log_dat.push_back(bus.data_in);
      cap_addr = bus.address;
      cap_rw   = bus.read_write;
      cap_dat  = bus.data_in;
      if (!hang) begin
        m_endcmd = 1'b0;
        mcnt     = 3;
        if (bus.read_write == RW_WRITE) mem[bus.address] = bus.data_in;
      end
    end else begin
      qs_run = 0;
      if (mcnt > 0) begin
        if (bus.address !== cap_addr || bus.read_write !== cap_rw || bus.data_in !== cap_dat)
          stab_cnt++;
        mcnt--;
        if (mcnt == 0) begin
          m_endcmd = 1'b1;
          m_dout   = mem.exists(cap_addr) ? mem[cap_addr] : 16'h0000;
        end
      end
    end
    if (rd_valid === 1'b1) begin
      rv_run++;
      rv_cnt++;
      if (rv_run > 1) rv_wide_cnt++;
    end else begin
      rv_run = 0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge mem_clk);
  endtask

  task automatic wait_qs(input int maxc, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < maxc) begin
      @(negedge mem_clk);
      i++;
      if (bus.quad_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_rw_idle(input int maxc, output bit ok);
    int i = 0;
    ok = 1'b0;
    while (!ok && i < maxc) begin
      @(negedge mem_clk);
      i++;
      if (bus.read_write === RW_NONE) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    @(negedge mem_clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL reset_rd_ready: got %b want 1", rd_ready); end
    checks++; if (wr_ptr !== 23'h0) begin errors++; $display("FAIL reset_wr_ptr: got %h want 0", wr_ptr); end
    checks++; if ({wrapped, wr_overflow, rd_valid, busy} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {wrapped, wr_overflow, rd_valid, busy}); end
    checks++; if ({bus.read_write, bus.quad_start} !== 3'b0) begin errors++; $display("FAIL reset_bus: got %b want 000", {bus.read_write, bus.quad_start}); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
`ifdef PSRAM_ARB_TIMEOUT_EN
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout: got %b want 0", err_timeout); end
`endif
    qpi_on  = 1'b1;
    wr_data = 16'hA5A5;
    wr_req  = 1'b1;
    @(negedge mem_clk);
    wr_req = 1'b0;
    cycles(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_hold_busy: got %b want 0", busy); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL init_wr_accepted: got %b want 0", wr_ready); end
  endtask

  task automatic test_single_write();
    bit ok;
    int qw0 = qs_wide_cnt;
    int s0  = stab_cnt;
    wait_qs(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_quad_start: got none want pulse"); end
    checks++; if (bus.address !== 23'h0) begin errors++; $display("FAIL wr_address: got %h want 0", bus.address); end
    checks++; if (bus.read_write !== RW_WRITE) begin errors++; $display("FAIL wr_rw: got %0d want 1", bus.read_write); end
    checks++; if (bus.data_in !== 16'hA5A5) begin errors++; $display("FAIL wr_data_in: got %h want a5a5", bus.data_in); end
    wait_rw_idle(50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr_complete: got busy want rw=0"); end
    checks++; if (qs_wide_cnt !== qw0) begin errors++; $display("FAIL wr_qs_width: got %0d extra want 0", qs_wide_cnt - qw0); end
    checks++; if (stab_cnt !== s0) begin errors++; $display("FAIL wr_bus_stable: got %0d changes want 0", stab_cnt - s0); end
    checks++; if (wr_ptr !== 23'h2) begin errors++; $display("FAIL wr_ptr_inc: got %h want 2", wr_ptr); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wr_release: got %b want 1", wr_ready); end
  endtask

  task automatic test_read();
    bit ok;
    int i = 0;
    int rw0 = rv_wide_cnt;
    rd_addr = 23'h000010;
    rd_req  = 1'b1;
    @(negedge mem_clk);
    rd_req = 1'b0;
    checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL rd_accept: got %b want 0", rd_ready); end
    wait_qs(20, ok);
    checks++; if (!ok || bus.read_write !== RW_READ) begin errors++; $display("FAIL rd_rw: got %0d want 2", bus.read_write); end
    checks++; if (bus.address !== 23'h10) begin errors++; $display("FAIL rd_address: got %h want 10", bus.address); end
    while (rd_valid !== 1'b1 && i < 30) begin @(negedge mem_clk); i++; end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin errors++; $display("FAIL rd_data: got %h want 1234", rd_data); end
    @(negedge mem_clk);
    checks++; if (rd_valid !== 1'b0 || rv_wide_cnt !== rw0) begin errors++; $display("FAIL rd_valid_pulse: got %b want 0", rd_valid); end
    checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rd_release: got %b want 1", rd_ready); end
  endtask

  task automatic test_overflow();
    int n0 = log_rw.size();
    int bad = 0;
    int i = 0;
    addr_t p0 = wr_ptr;
    wr_data = 16'h1111; wr_req = 1'b1;
    @(negedge mem_clk);
    wr_data = 16'h2222;
    @(negedge mem_clk);
    wr_data = 16'h3333;
    @(negedge mem_clk);
    wr_req = 1'b0;
    checks++; if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", wr_overflow); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_low: got %b want 0", wr_ready); end
    while (bus.read_write !== RW_NONE && i < 50) begin
      @(negedge mem_clk);
      i++;
      if (m_endcmd === 1'b0 && wr_ready === 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_ready_in_flight: got %0d cycles high want 0", bad); end
    checks++; if (wr_ptr !== p0 + 23'd2) begin errors++; $display("FAIL ovf_wr_ptr: got %h want %h", wr_ptr, p0 + 23'd2); end
    cycles(20);
    checks++; if (log_rw.size() != n0 + 1) begin errors++; $display("FAIL ovf_single_op: got %0d ops want 1", log_rw.size() - n0); end
    checks++; if (log_rw.size() <= n0 || log_dat[n0] !== 16'h1111) begin errors++; $display("FAIL ovf_kept_word: got other want 1111"); end
  endtask

  task automatic test_starvation();
    int n0 = log_rw.size();
    int nwr = 0;
    int i = 0;
    bit found = 1'b0;
    mem[23'h20] = 16'h4321;
    wr_data = 16'h5555; wr_req = 1'b1;
    rd_addr = 23'h20;   rd_req = 1'b1;
    @(negedge mem_clk);
    rd_req = 1'b0;
    while (!found && i < 300) begin
      @(negedge mem_clk);
      i++;
      for (int k = n0; k < log_rw.size(); k++) if (log_rw[k] == RW_READ) found = 1'b1;
    end
    wr_req = 1'b0;
    for (int k = n0; k < log_rw.size() && log_rw[k] != RW_READ; k++) nwr++;
    checks++; if (!found) begin errors++; $display("FAIL starve_read_granted: got none want read"); end
    checks++; if (nwr != 4) begin errors++; $display("FAIL starve_limit: got %0d writes want 4", nwr); end
    i = 0;
    while (rd_valid !== 1'b1 && i < 30) begin @(negedge mem_clk); i++; end
    checks++; if (rd_data !== 16'h4321) begin errors++; $display("FAIL starve_rd_data: got %h want 4321", rd_data); end
    cycles(30);
  endtask

  task automatic test_reset_and_wrap();
    bit ok;
    int i = 0;
    wr_data = 16'h7777; wr_req = 1'b1;
    @(negedge mem_clk);
    wr_req = 1'b0;
    wait_qs(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midop_start: got none want pulse"); end
    rst_n = 1'b0;
    @(negedge mem_clk);
    checks++; if ({busy, bus.read_write} !== 3'b0) begin errors++; $display("FAIL midop_idle: got %b want 000", {busy, bus.read_write}); end
    checks++; if (wr_ptr !== 23'h0 || wr_ready !== 1'b1) begin errors++; $display("FAIL midop_ptr: got %h/%b want 0/1", wr_ptr, wr_ready); end
    checks++; if ({wr_overflow, wrapped} !== 2'b0) begin errors++; $display("FAIL midop_sticky: got %b want 00", {wr_overflow, wrapped}); end
    rst_n = 1'b1;
    wr_data = 16'hBEEF; wr_req = 1'b1;
    while (wr_ptr !== 23'h1FFE && i < 40000) begin @(negedge mem_clk); i++; end
    checks++; if (wr_ptr !== 23'h1FFE) begin errors++; $display("FAIL wrap_reach_end: got %h want 1ffe", wr_ptr); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL wrap_early: got %b want 0", wrapped); end
    i = 0;
    while (wr_ptr !== 23'h0 && i < 40) begin @(negedge mem_clk); i++; end
    checks++; if (wr_ptr !== 23'h0) begin errors++; $display("FAIL wrap_ptr: got %h want 0", wr_ptr); end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag: got %b want 1", wrapped); end
    checks++; if (log_addr[log_addr.size() - 1] !== 23'h1FFE) begin errors++; $display("FAIL wrap_last_addr: got %h want 1ffe", log_addr[log_addr.size() - 1]); end
    wr_req = 1'b0;
    cycles(30);
  endtask

`ifdef PSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int i = 0;
    addr_t a0 = wr_ptr;
    hang = 1'b1;
    wr_data = 16'hC0DE; wr_req = 1'b1;
    @(negedge mem_clk);
    wr_req = 1'b0;
    wait_qs(20, ok);
    checks++; if (!ok || bus.address !== a0) begin errors++; $display("FAIL to_first_addr: got %h want %h", bus.address, a0); end
    while (err_timeout !== 1'b1 && i < 100) begin @(negedge mem_clk); i++; end
    checks++; if (err_timeout !== 1'b1 || i < 60) begin errors++; $display("FAIL to_flag: got %b after %0d want 1 after ~64", err_timeout, i); end
    checks++; if (wr_ptr !== a0) begin errors++; $display("FAIL to_ptr_kept: got %h want %h", wr_ptr, a0); end
    hang = 1'b0;
    wait_qs(20, ok);
    checks++; if (!ok || bus.address !== a0 || bus.data_in !== 16'hC0DE) begin errors++; $display("FAIL to_retry: got %h want %h", bus.address, a0); end
    wait_rw_idle(40, ok);
    checks++; if (wr_ptr !== a0 + 23'd2) begin errors++; $display("FAIL to_retry_done: got %h want %h", wr_ptr, a0 + 23'd2); end
  endtask
`endif

  initial begin
    mem[23'h10] = 16'h1234;
    test_reset();
    test_single_write();
    test_read();
    test_overflow();
    test_starvation();
    test_reset_and_wrap();
`ifdef PSRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(12 * 90000);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
